case_match_table: RTL and testbench

Programmable, pipelined successor to the fixed combinational case decoder. It holds ENTRIES value/care/result rows and looks up keys against them with casez-style priority: the lowest-indexed enabled row wins, and a default result is returned on a miss. Lookups use a valid/ready handshake, and saturating hit/miss statistics are kept. It sits between a key producer and any consumer of decoded results, and is also used as a systest vehicle for case/casez lowering under sequential control.

---
 rtl/case_match_table.sv | 209 ++++++++++++++++++++
 tb/tb_case_match_table.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/case_match_table.sv
// Programmable casez-style match table with a two-stage valid/ready lookup pipeline
// and saturating hit/miss statistics.
module case_match_table #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned IDXW    = 2,
    parameter int unsigned OUTW    = 3,
    parameter int unsigned MODE    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic             cfg_en,
    input  logic [WIDTH-1:0] cfg_val,
    input  logic [WIDTH-1:0] cfg_care,
    input  logic [OUTW-1:0]  cfg_res,
    input  logic             dflt_we,
    input  logic [OUTW-1:0]  dflt_res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [IDXW-1:0]  out_idx,
    output logic [OUTW-1:0]  out_res,
    input  logic             stat_clr,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
);

    localparam int unsigned CNTW = 16;

    logic [ENTRIES-1:0]            en_q, en_d;
    logic [ENTRIES-1:0][WIDTH-1:0] val_q, val_d;
    logic [ENTRIES-1:0][WIDTH-1:0] care_q, care_d;
    logic [ENTRIES-1:0][OUTW-1:0]  res_q, res_d;
    logic [OUTW-1:0]               dflt_q, dflt_d;

    logic                          s1_valid_q, s1_valid_d;
    logic                          s1_hit_q, s1_hit_d;
    logic [IDXW-1:0]               s1_idx_q, s1_idx_d;
    logic [OUTW-1:0]               s1_res_q, s1_res_d;

    logic                          out_valid_q, out_valid_d;
    logic                          out_hit_q, out_hit_d;
    logic [IDXW-1:0]               out_idx_q, out_idx_d;
    logic [OUTW-1:0]               out_res_q, out_res_d;

    logic [CNTW-1:0]               hit_cnt_q, hit_cnt_d;
    logic [CNTW-1:0]               miss_cnt_q, miss_cnt_d;

    logic [ENTRIES-1:0]            match_c;
    logic                          lk_hit_c;
    logic [IDXW-1:0]               lk_idx_c;
    logic [OUTW-1:0]               lk_res_c;
    logic                          s2_load_c;
    logic                          s1_load_c;
    logic                          accept_c;

    // Row compare; an unknown key bit under care falls through the if and reads as a mismatch.
    always_comb begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
            match_c[i] = 1'b0;
            if (en_q[i]) begin
                if (MODE != 0) begin
                    if (((in_key ^ val_q[i]) & care_q[i]) == '0) begin
                        match_c[i] = 1'b1;
                    end
                end else begin
                    if (in_key == val_q[i]) begin
                        match_c[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Priority encode: scan downwards so the lowest matching row is written last.
    always_comb begin
        lk_hit_c = 1'b0;
        lk_idx_c = '0;
        lk_res_c = dflt_q;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (match_c[i]) begin
                lk_hit_c = 1'b1;
                lk_idx_c = IDXW'(i);
                lk_res_c = res_q[i];
            end
        end
    end

    assign s2_load_c = !out_valid_q || out_ready;
    assign s1_load_c = !s1_valid_q || s2_load_c;
    assign accept_c  = in_valid && s1_load_c;
    assign in_ready  = s1_load_c;

    // Table writes land at the edge, so a same-cycle lookup still sees the old contents.
    always_comb begin
        en_d   = en_q;
        val_d  = val_q;
        care_d = care_q;
        res_d  = res_q;
        dflt_d = dflt_q;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (cfg_we && (cfg_idx == IDXW'(i))) begin
                en_d[i]   = cfg_en;
                val_d[i]  = cfg_val;
                care_d[i] = cfg_care;
                res_d[i]  = cfg_res;
            end
        end
        if (dflt_we) begin
            dflt_d = dflt_res;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_hit_d    = s1_hit_q;
        s1_idx_d    = s1_idx_q;
        s1_res_d    = s1_res_q;
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        out_idx_d   = out_idx_q;
        out_res_d   = out_res_q;
        if (s1_load_c) begin
            s1_valid_d = accept_c;
        end
        if (accept_c) begin
            s1_hit_d = lk_hit_c;
            s1_idx_d = lk_idx_c;
            s1_res_d = lk_res_c;
        end
        if (s2_load_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_hit_d = s1_hit_q;
                out_idx_d = s1_idx_q;
                out_res_d = s1_res_q;
            end
        end
    end

    // Statistics count deliveries, not accepts; clear wins over a same-cycle increment.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (stat_clr) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (out_hit_q) begin
                if (hit_cnt_q != '1) begin
                    hit_cnt_d = hit_cnt_q + CNTW'(1);
                end
            end else begin
                if (miss_cnt_q != '1) begin
                    miss_cnt_d = miss_cnt_q + CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= '0;
            val_q       <= '0;
            care_q      <= '0;
            res_q       <= '0;
            dflt_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            s1_idx_q    <= '0;
            s1_res_q    <= '0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
            out_res_q   <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            en_q        <= en_d;
            val_q       <= val_d;
            care_q      <= care_d;
            res_q       <= res_d;
            dflt_q      <= dflt_d;
            s1_valid_q  <= s1_valid_d;
            s1_hit_q    <= s1_hit_d;
            s1_idx_q    <= s1_idx_d;
            s1_res_q    <= s1_res_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_idx_q   <= out_idx_d;
            out_res_q   <= out_res_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_idx   = out_idx_q;
    assign out_res   = out_res_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_case_match_table.sv
// Bench for case_match_table: wildcard and exact-compare instances share stimulus and are
// checked every cycle against a queue-based reference of the table and pipeline.
module tb_case_match_table;

    typedef struct {
        logic       hit;
        logic [1:0] idx;
        logic [2:0] res;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we, cfg_en, dflt_we, in_valid, out_ready, stat_clr;
    logic [1:0] cfg_idx;
    logic [2:0] cfg_val, cfg_care, cfg_res, dflt_res, in_key;

    logic        in_ready, out_valid, out_hit;
    logic [1:0]  out_idx;
    logic [2:0]  out_res;
    logic [15:0] hit_cnt, miss_cnt;

    logic        in_ready_x, out_valid_x, out_hit_x;
    logic [1:0]  out_idx_x;
    logic [2:0]  out_res_x;
    logic [15:0] hit_cnt_x, miss_cnt_x;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit last_acc;

    logic       m_en   [4];
    logic [2:0] m_val  [4];
    logic [2:0] m_care [4];
    logic [2:0] m_res  [4];
    logic [2:0] m_dflt;
    int         m_hits, m_miss;
    exp_t       q  [$];
    exp_t       qx [$];

    always #5 clk = ~clk;

    case_match_table #(.WIDTH(3), .ENTRIES(4), .IDXW(2), .OUTW(3), .MODE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_val(cfg_val), .cfg_care(cfg_care), .cfg_res(cfg_res), .dflt_we(dflt_we),
        .dflt_res(dflt_res), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_idx(out_idx),
        .out_res(out_res), .stat_clr(stat_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    case_match_table #(.WIDTH(3), .ENTRIES(4), .IDXW(2), .OUTW(3), .MODE(0)) u_exact (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_val(cfg_val), .cfg_care(cfg_care), .cfg_res(cfg_res), .dflt_we(dflt_we),
        .dflt_res(dflt_res), .in_valid(in_valid), .in_ready(in_ready_x), .in_key(in_key),
        .out_valid(out_valid_x), .out_ready(out_ready), .out_hit(out_hit_x),
        .out_idx(out_idx_x), .out_res(out_res_x), .stat_clr(stat_clr),
        .hit_cnt(hit_cnt_x), .miss_cnt(miss_cnt_x)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // First enabled row (lowest index) whose cared bits all equal the key wins.
    function automatic exp_t lookup(input logic [2:0] key, input bit exact);
        exp_t r;
        bit   ok;
        r.hit = 1'b0;
        r.idx = 2'd0;
        r.res = m_dflt;
        r.acc = cyc;
        for (int i = 0; i < 4; i++) begin
            ok = m_en[i];
            for (int b = 0; b < 3; b++) begin
                if ((exact || m_care[i][b]) && (key[b] != m_val[i][b])) ok = 1'b0;
            end
            if (ok) begin
                r.hit = 1'b1;
                r.idx = 2'(i);
                r.res = m_res[i];
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 1'b0; m_val[i] = 3'd0; m_care[i] = 3'd0; m_res[i] = 3'd0;
        end
        m_dflt = 3'd0;
        m_hits = 0;
        m_miss = 0;
        q.delete();
        qx.delete();
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic tick();
        bit   ir, ov, dlv;
        exp_t h;
        #2;
        ir = (q.size() < 2) || out_ready;
        ov = (q.size() > 0) && (q[0].acc <= cyc - 2);
        chk("in_ready", 32'(in_ready), 32'(ir));
        chk("in_ready_x", 32'(in_ready_x), 32'(ir));
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("out_valid_x", 32'(out_valid_x), 32'(ov));
        if (ov) begin
            chk("out_hit", 32'(out_hit), 32'(q[0].hit));
            chk("out_idx", 32'(out_idx), 32'(q[0].idx));
            chk("out_res", 32'(out_res), 32'(q[0].res));
            chk("out_hit_x", 32'(out_hit_x), 32'(qx[0].hit));
            chk("out_idx_x", 32'(out_idx_x), 32'(qx[0].idx));
            chk("out_res_x", 32'(out_res_x), 32'(qx[0].res));
        end
        chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
        chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
        dlv = ov && out_ready;
        if (stat_clr) begin
            m_hits = 0;
            m_miss = 0;
        end else if (dlv) begin
            if (q[0].hit) m_hits = (m_hits < 65535) ? m_hits + 1 : 65535;
            else          m_miss = (m_miss < 65535) ? m_miss + 1 : 65535;
        end
        if (dlv) begin
            h = q.pop_front();
            h = qx.pop_front();
        end
        last_acc = in_valid && ir;
        if (last_acc) begin
            q.push_back(lookup(in_key, 1'b0));
            qx.push_back(lookup(in_key, 1'b1));
        end
        if (cfg_we) begin
            m_en[cfg_idx] = cfg_en; m_val[cfg_idx] = cfg_val;
            m_care[cfg_idx] = cfg_care; m_res[cfg_idx] = cfg_res;
        end
        if (dflt_we) m_dflt = dflt_res;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_row(input logic [1:0] idx, input logic en, input logic [2:0] val,
                           input logic [2:0] care, input logic [2:0] res);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_val = val; cfg_care = care; cfg_res = res;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (n) tick();
    endtask

    task automatic check_zero_outputs();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_hit", 32'(out_hit), 32'd0);
        chk("rst out_idx", 32'(out_idx), 32'd0);
        chk("rst out_res", 32'(out_res), 32'd0);
        chk("rst hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst miss_cnt", 32'(miss_cnt), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
    endtask

    logic [2:0] keys [4];
    int         k, n;

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_idx = 2'd0; cfg_en = 1'b0; cfg_val = 3'd0; cfg_care = 3'd0;
        cfg_res = 3'd0; dflt_we = 1'b0; dflt_res = 3'd0; in_valid = 1'b0; in_key = 3'd0;
        out_ready = 1'b1; stat_clr = 1'b0;
        model_clear();
        #12;
        check_zero_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // Priority table, back-to-back keys.
        cfg_row(2'd0, 1'b1, 3'b100, 3'b100, 3'd0);
        cfg_row(2'd1, 1'b1, 3'b010, 3'b110, 3'd1);
        cfg_row(2'd2, 1'b1, 3'b001, 3'b111, 3'd2);
        cfg_row(2'd3, 1'b1, 3'b000, 3'b111, 3'd3);
        in_valid = 1'b1;
        in_key = 3'b110; tick();
        in_key = 3'b011; tick();
        in_key = 3'b001; tick();
        in_key = 3'b000; tick();
        drain(3);

        // Miss path and default result.
        cfg_row(2'd0, 1'b0, 3'b100, 3'b100, 3'd0);
        in_valid = 1'b1; in_key = 3'b111; tick();
        drain(3);
        dflt_we = 1'b1; dflt_res = 3'd5; tick();
        dflt_we = 1'b0;
        in_valid = 1'b1; in_key = 3'b111; tick();
        drain(3);

        // Care mask ignored by the exact instance, honoured by the wildcard one.
        cfg_row(2'd0, 1'b1, 3'b101, 3'b000, 3'd4);
        in_valid = 1'b1;
        in_key = 3'b101; tick();
        in_key = 3'b100; tick();
        drain(3);

        // Full stall then release.
        cfg_row(2'd0, 1'b0, 3'b000, 3'b000, 3'd0);
        keys[0] = 3'b011; keys[1] = 3'b001; keys[2] = 3'b000; keys[3] = 3'b110;
        k = 0;
        n = 0;
        while (k < 4 && n < 30) begin
            in_valid = 1'b1;
            in_key = keys[k];
            out_ready = (n >= 5);
            tick();
            if (last_acc) k++;
            n++;
        end
        chk("stall accepted all", 32'(k), 32'd4);
        drain(4);

        // Row rewritten in the accept cycle: old result first, new one next.
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_en = 1'b1; cfg_val = 3'b010; cfg_care = 3'b110;
        cfg_res = 3'd7; in_valid = 1'b1; in_key = 3'b011;
        tick();
        cfg_we = 1'b0;
        tick();
        drain(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_idx = 2'($urandom_range(0, 3));
            cfg_en = 1'($urandom);
            cfg_val = 3'($urandom);
            cfg_care = 3'($urandom);
            cfg_res = 3'($urandom);
            dflt_we = ($urandom_range(0, 15) == 0);
            dflt_res = 3'($urandom);
            in_valid = 1'($urandom);
            in_key = 3'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            stat_clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        cfg_we = 1'b0; dflt_we = 1'b0; stat_clr = 1'b0;
        drain(4);

        // Hit counter saturation and clear-over-increment.
        stat_clr = 1'b1; tick();
        stat_clr = 1'b0;
        cfg_row(2'd0, 1'b1, 3'b000, 3'b000, 3'd6);
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (m_hits < 65534 && n < 70000) begin
            in_key = 3'($urandom);
            tick();
            n++;
        end
        chk("reached FFFE", 32'(hit_cnt), 32'h0000_FFFE);
        repeat (5) begin
            in_key = 3'($urandom);
            tick();
        end
        chk("saturated", 32'(hit_cnt), 32'h0000_FFFF);
        stat_clr = 1'b1; tick();
        stat_clr = 1'b0;
        chk("clear wins", 32'(hit_cnt), 32'd0);
        tick();

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        check_zero_outputs();
        model_clear();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_key = 3'b101; tick();
        drain(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
